mem_port_arbiter: RTL and testbench

- Shares one single-ported memory interface between two requesters: the processor's instruction-fetch port (F stage) and its data-memory port (M stage).
- Arbitrates between the requests, allows at most one transaction in flight, and routes each memory response back to the requester that issued it.
- Sits between the TinyRV1 processor's imem/dmem ports and a single memory model or SRAM wrapper.
- Includes a starvation guard so that sustained data traffic cannot lock out fetch.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (imem) and data (dmem) ports.
// One transaction in flight; responses are routed back to the requester that issued them.
module mem_port_arbiter #(
  parameter int unsigned RR       = 0,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data,
  output logic [1:0]  trace_grant
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
  localparam bit RR_MODE = (RR != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             last_d;     // 1 when dmem was the most recent fired winner
  logic             grant_i;
  logic             grant_d;
  logic             fire_i;
  logic             fire_d;

  // Winner selection; grants are only meaningful while IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (imemreq_val && !dmemreq_val) begin
        grant_i = 1'b1;
      end else if (dmemreq_val && !imemreq_val) begin
        grant_d = 1'b1;
      end else if (imemreq_val && dmemreq_val) begin
        if (starve_cnt == WAIT_LIM) begin
          grant_i = 1'b1;
        end else if (!RR_MODE) begin
          grant_d = 1'b1;
        end else if (last_d) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end
    end
    fire_i = grant_i & memreq_rdy;
    fire_d = grant_d & memreq_rdy;
  end

  // Request steering and response routing
  always_comb begin
    memreq_val    = grant_i | grant_d;
    memreq_type   = grant_d & dmemreq_type;
    memreq_addr   = grant_d ? dmemreq_addr : (grant_i ? imemreq_addr : 32'd0);
    memreq_wdata  = grant_d ? dmemreq_wdata : 32'd0;
    imemreq_rdy   = fire_i;
    dmemreq_rdy   = fire_d;
    imemresp_val  = (state == BUSY_I) & memresp_val;
    dmemresp_val  = (state == BUSY_D) & memresp_val;
    imemresp_data = imemresp_val ? memresp_data : 32'd0;
    dmemresp_data = dmemresp_val ? memresp_data : 32'd0;
    trace_grant   = 2'b00;
    case (state)
      IDLE:    trace_grant = {grant_d, grant_i};
      BUSY_I:  trace_grant = 2'b01;
      BUSY_D:  trace_grant = 2'b10;
      default: trace_grant = 2'b00;
    endcase
  end

  // Ownership state, starvation counter and last-grant memory
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      last_d     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_i) begin
            state  <= BUSY_I;
            last_d <= 1'b0;
          end else if (fire_d) begin
            state  <= BUSY_D;
            last_d <= 1'b1;
          end
          if (!imemreq_val || fire_i) begin
            starve_cnt <= '0;
          end else if (starve_cnt != WAIT_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        BUSY_I, BUSY_D: begin
          if (memresp_val) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected fires/responses are queued by the stimulus and
// checked by independent monitors against a fixed-priority and a round-robin instance.
module tb_mem_port_arbiter;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] addr;
    logic        typ;
    logic [31:0] wdata;
  } fire_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        iv, dv, dtype, mem_rdy, mresp_val;
  logic [31:0] iaddr, daddr, dwdata, mresp_data;

  // Per-instance outputs (a: RR=0, b: RR=1)
  logic        a_irdy, a_irv, a_drdy, a_drv, a_mv, a_mt;
  logic [31:0] a_ird, a_drd, a_ma, a_mw;
  logic [1:0]  a_tg;
  logic        b_irdy, b_irv, b_drdy, b_drv, b_mv, b_mt;
  logic [31:0] b_ird, b_drd, b_ma, b_mw;
  logic [1:0]  b_tg;

  // Views of whichever instance is selected
  logic        imemreq_rdy, imemresp_val, dmemreq_rdy, dmemresp_val, memreq_val, memreq_type;
  logic [31:0] imemresp_data, dmemresp_data, memreq_addr, memreq_wdata;
  logic [1:0]  trace_grant;
  logic        memreq_rdy;

  assign memreq_rdy    = mem_rdy;
  assign imemreq_rdy   = sel ? b_irdy : a_irdy;
  assign imemresp_val  = sel ? b_irv  : a_irv;
  assign imemresp_data = sel ? b_ird  : a_ird;
  assign dmemreq_rdy   = sel ? b_drdy : a_drdy;
  assign dmemresp_val  = sel ? b_drv  : a_drv;
  assign dmemresp_data = sel ? b_drd  : a_drd;
  assign memreq_val    = sel ? b_mv   : a_mv;
  assign memreq_type   = sel ? b_mt   : a_mt;
  assign memreq_addr   = sel ? b_ma   : a_ma;
  assign memreq_wdata  = sel ? b_mw   : a_mw;
  assign trace_grant   = sel ? b_tg   : a_tg;

  mem_port_arbiter #(.RR(0), .MAX_WAIT(4)) dut_fp (
    .clk(clk), .rst(rst),
    .imemreq_val(iv & ~sel), .imemreq_rdy(a_irdy), .imemreq_addr(iaddr),
    .imemresp_val(a_irv), .imemresp_data(a_ird),
    .dmemreq_val(dv & ~sel), .dmemreq_rdy(a_drdy), .dmemreq_type(dtype),
    .dmemreq_addr(daddr), .dmemreq_wdata(dwdata),
    .dmemresp_val(a_drv), .dmemresp_data(a_drd),
    .memreq_val(a_mv), .memreq_rdy(mem_rdy), .memreq_type(a_mt),
    .memreq_addr(a_ma), .memreq_wdata(a_mw),
    .memresp_val(mresp_val & ~sel), .memresp_data(mresp_data),
    .trace_grant(a_tg)
  );

  mem_port_arbiter #(.RR(1), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst(rst),
    .imemreq_val(iv & sel), .imemreq_rdy(b_irdy), .imemreq_addr(iaddr),
    .imemresp_val(b_irv), .imemresp_data(b_ird),
    .dmemreq_val(dv & sel), .dmemreq_rdy(b_drdy), .dmemreq_type(dtype),
    .dmemreq_addr(daddr), .dmemreq_wdata(dwdata),
    .dmemresp_val(b_drv), .dmemresp_data(b_drd),
    .memreq_val(b_mv), .memreq_rdy(mem_rdy), .memreq_type(b_mt),
    .memreq_addr(b_ma), .memreq_wdata(b_mw),
    .memresp_val(mresp_val & sel), .memresp_data(mresp_data),
    .trace_grant(b_tg)
  );

  int    errors = 0;
  int    checks = 0;
  int    lat    = 1;
  fire_t fire_q[$];
  resp_t resp_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h00A0_0093;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: fixed latency, one outstanding request
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] raddr;
    pend = 1'b0; cnt = 0; raddr = '0;
    mresp_val = 1'b0; mresp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && memreq_val && memreq_rdy) begin
        pend = 1'b1; cnt = lat; raddr = memreq_addr;
      end
      @(posedge clk); #1;
      mresp_val = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          mresp_val = 1'b1; mresp_data = mem_data(raddr); pend = 1'b0;
        end
      end
    end
  end

  // Request-fire monitor
  initial begin
    fire_t fe;
    forever begin
      @(negedge clk);
      if (!rst && memreq_val && memreq_rdy) begin
        checks++;
        if (fire_q.size() == 0) begin
          errors++;
          $display("FAIL fire_unexpected: grant=%b addr=%h, required no fire", trace_grant, memreq_addr);
        end else begin
          fe = fire_q.pop_front();
          if ({trace_grant, memreq_addr, memreq_type, memreq_wdata} !== {fe.g, fe.addr, fe.typ, fe.wdata}) begin
            errors++;
            $display("FAIL fire: grant=%b addr=%h type=%b wdata=%h, required grant=%b addr=%h type=%b wdata=%h",
                     trace_grant, memreq_addr, memreq_type, memreq_wdata, fe.g, fe.addr, fe.typ, fe.wdata);
          end
        end
      end
    end
  end

  // Response-routing monitor
  initial begin
    resp_t re;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (imemresp_val || dmemresp_val) begin
        checks++;
        got = dmemresp_val ? dmemresp_data : imemresp_data;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: ival=%b dval=%b data=%h, required none", imemresp_val, dmemresp_val, got);
        end else begin
          re = resp_q.pop_front();
          if ({dmemresp_val, imemresp_val, got} !== {re.is_d, ~re.is_d, re.data}) begin
            errors++;
            $display("FAIL resp: dval=%b ival=%b data=%h, required dval=%b ival=%b data=%h",
                     dmemresp_val, imemresp_val, got, re.is_d, ~re.is_d, re.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic exp_fire(input logic [1:0] g, input logic [31:0] a, input logic t, input logic [31:0] w);
    fire_t f;
    f.g = g; f.addr = a; f.typ = t; f.wdata = w;
    fire_q.push_back(f);
  endtask

  task automatic exp_resp(input logic d, input logic [31:0] data);
    resp_t r;
    r.is_d = d; r.data = data;
    resp_q.push_back(r);
  endtask

  task automatic wait_fires();
    int n = 0;
    while (fire_q.size() != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (fire_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL fire_timeout: %0d fires outstanding, required 0", fire_q.size());
      fire_q.delete();
    end
  endtask

  task automatic wait_resps();
    int n = 0;
    while (resp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (resp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", resp_q.size());
      resp_q.delete();
    end
    tick(); tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0; iv = 1'b0; dv = 1'b0; dtype = 1'b0; mem_rdy = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0;
    tick(); tick();

    // Reset: every output low with inputs low
    @(negedge clk);
    check("reset_ctrl", 64'({imemreq_rdy, imemresp_val, dmemreq_rdy, dmemresp_val,
                             memreq_val, memreq_type, trace_grant}), 64'd0);
    check("reset_data", 64'(imemresp_data | dmemresp_data | memreq_addr | memreq_wdata), 64'd0);
    check("reset_rr_inst", 64'({b_irdy, b_irv, b_drdy, b_drv, b_mv, b_mt, b_tg}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single fetch, latency 2
    lat = 2; mem_rdy = 1'b1;
    exp_fire(2'b01, 32'h200, 1'b0, 32'h0);
    exp_resp(1'b0, 32'h00A0_0093);
    iv = 1'b1; iaddr = 32'h200;
    wait_fires(); tick(); iv = 1'b0;
    wait_resps();

    // Fixed priority with starvation guard: 4 dmem then 1 imem, twice
    lat = 1; dtype = 1'b0; daddr = 32'h1000; dwdata = 32'h1111_1111; iaddr = 32'h300;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_fire(2'b10, 32'h1000, 1'b0, 32'h1111_1111);
        exp_resp(1'b1, mem_data(32'h1000));
      end
      exp_fire(2'b01, 32'h300, 1'b0, 32'h0);
      exp_resp(1'b0, mem_data(32'h300));
    end
    iv = 1'b1; dv = 1'b1;
    wait_fires(); tick(); iv = 1'b0; dv = 1'b0;
    wait_resps();

    // Round-robin instance: dmem alone first, then alternation starting at imem
    sel = 1'b1;
    tick();
    exp_fire(2'b10, 32'h1000, 1'b0, 32'h1111_1111);
    exp_resp(1'b1, mem_data(32'h1000));
    dv = 1'b1;
    wait_fires(); tick(); dv = 1'b0;
    wait_resps();
    for (int k = 0; k < 2; k++) begin
      exp_fire(2'b01, 32'h300, 1'b0, 32'h0);
      exp_resp(1'b0, mem_data(32'h300));
      exp_fire(2'b10, 32'h1000, 1'b0, 32'h1111_1111);
      exp_resp(1'b1, mem_data(32'h1000));
    end
    iv = 1'b1; dv = 1'b1;
    wait_fires(); tick(); iv = 1'b0; dv = 1'b0;
    wait_resps();
    sel = 1'b0;
    tick();

    // Write held off by memreq_rdy for 3 cycles
    lat = 2; mem_rdy = 1'b0;
    dv = 1'b1; dtype = 1'b1; daddr = 32'h2000; dwdata = 32'hDEAD_BEEF;
    exp_fire(2'b10, 32'h2000, 1'b1, 32'hDEAD_BEEF);
    exp_resp(1'b1, mem_data(32'h2000));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_val_type_rdy", 64'({memreq_val, memreq_type, dmemreq_rdy}), 64'b110);
      check("stall_addr", 64'(memreq_addr), 64'h2000);
      check("stall_wdata", 64'(memreq_wdata), 64'hDEAD_BEEF);
      tick();
    end
    mem_rdy = 1'b1;
    wait_fires(); tick(); dv = 1'b0; dtype = 1'b0;
    wait_resps();

    // Fetch arriving while dmem is in flight waits for the first IDLE cycle
    lat = 3; daddr = 32'h1000; dwdata = 32'h1111_1111;
    exp_fire(2'b10, 32'h1000, 1'b0, 32'h1111_1111);
    exp_resp(1'b1, mem_data(32'h1000));
    dv = 1'b1;
    wait_fires(); tick(); dv = 1'b0;
    iv = 1'b1; iaddr = 32'h400;
    exp_fire(2'b01, 32'h400, 1'b0, 32'h0);
    exp_resp(1'b0, mem_data(32'h400));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_blocks_imem", 64'({imemreq_rdy, memreq_val}), 64'd0);
      tick();
    end
    @(negedge clk);
    check("imem_first_idle", 64'({imemreq_rdy, trace_grant}), 64'b101);
    #1;
    wait_fires(); tick(); iv = 1'b0;
    wait_resps();

    // Reset during BUSY_I; the late response must be dropped
    lat = 3; iaddr = 32'h500;
    exp_fire(2'b01, 32'h500, 1'b0, 32'h0);
    iv = 1'b1;
    wait_fires(); tick(); iv = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'({trace_grant, memreq_val, imemresp_val, dmemresp_val}), 64'd0);
    repeat (4) tick();
    daddr = 32'h1004;
    exp_fire(2'b10, 32'h1004, 1'b0, 32'h1111_1111);
    exp_resp(1'b1, mem_data(32'h1004));
    dv = 1'b1;
    wait_fires(); tick(); dv = 1'b0;
    wait_resps();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
